scroll_ctrl: RTL

- Sequencer that feeds the 8-digit seven-segment multiplexer.
- Holds a message buffer of raw segment patterns and presents a sliding 8-character window on eight 8-bit digit outputs, which drive the mux inputs in7..in0.
- Advances the window one character per programmable step period, with start, stop, pause and direction control.
- Sits between the character source (host or pattern ROM) and the display mux.

---
 rtl/scroll_ctrl.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/scroll_ctrl.sv
// Scrolling message sequencer: shows an 8-character sliding window of a segment-pattern
// buffer on d7..d0 and steps it left or right every div_q clock cycles.
module scroll_ctrl #(
   parameter int DEPTH  = 16,
   parameter int TICK_W = 26,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [7:0]        wr_data,
   input  logic [AW:0]       len,
   input  logic [TICK_W-1:0] div,
   input  logic              go,
   input  logic              stop,
   input  logic              pause,
   input  logic              dir,
   output logic [7:0]        d7,
   output logic [7:0]        d6,
   output logic [7:0]        d5,
   output logic [7:0]        d4,
   output logic [7:0]        d3,
   output logic [7:0]        d2,
   output logic [7:0]        d1,
   output logic [7:0]        d0,
   output logic              busy,
   output logic [AW-1:0]     pos,
   output logic              step,
   output logic              wrap
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED} state_t;

   localparam logic [AW:0] LEN_MAX = (AW+1)'(DEPTH);

   state_t            r_state, w_state_next;
   logic [7:0]        r_buf [DEPTH];
   logic [7:0]        r_dig [8];
   logic [AW-1:0]     r_pos, w_pos_next;
   logic [AW:0]       r_len, w_len_next;
   logic [TICK_W-1:0] r_div, w_div_next;
   logic [TICK_W-1:0] r_cnt, w_cnt_next;
   logic              r_step, w_step_next;
   logic              r_wrap, w_wrap_next;

   logic              w_len_ok;
   logic [TICK_W-1:0] w_div_eff;
   logic              w_last;
   logic [AW:0]       w_pos_inc_full;
   logic [AW-1:0]     w_pos_inc, w_pos_dec;
   logic [AW:0]       w_len_m1;
   logic [AW-1:0]     w_idx [8];
   logic [AW:0]       w_inc;

   assign w_len_ok       = (len != '0) && (len <= LEN_MAX);
   assign w_div_eff      = (div == '0) ? TICK_W'(1) : div;
   assign w_last         = (r_cnt == r_div - TICK_W'(1));
   assign w_len_m1       = r_len - (AW+1)'(1);
   assign w_pos_inc_full = {1'b0, r_pos} + (AW+1)'(1);
   assign w_pos_inc      = (w_pos_inc_full == r_len) ? '0 : w_pos_inc_full[AW-1:0];
   assign w_pos_dec      = (r_pos == '0) ? w_len_m1[AW-1:0] : r_pos - AW'(1);

   // Message buffer: writes accepted in every state, blanked by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) r_buf[i] <= 8'hFF;
      end else if (wr_en) begin
         r_buf[wr_addr] <= wr_data;
      end
   end

   // Window indices walk forward from pos, folding at len_q so short messages repeat
   always_comb begin
      w_inc    = '0;
      w_idx[0] = r_pos;
      for (int k = 1; k < 8; k++) begin
         w_inc    = {1'b0, w_idx[k-1]} + (AW+1)'(1);
         w_idx[k] = (w_inc == r_len) ? '0 : w_inc[AW-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset || r_state == S_IDLE) begin
         for (int k = 0; k < 8; k++) r_dig[k] <= 8'hFF;
      end else begin
         for (int k = 0; k < 8; k++) r_dig[k] <= r_buf[w_idx[k]];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_pos   <= '0;
         r_cnt   <= '0;
         r_len   <= (AW+1)'(1);
         r_div   <= TICK_W'(1);
         r_step  <= 1'b0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_pos   <= w_pos_next;
         r_cnt   <= w_cnt_next;
         r_len   <= w_len_next;
         r_div   <= w_div_next;
         r_step  <= w_step_next;
         r_wrap  <= w_wrap_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_pos_next   = r_pos;
      w_cnt_next   = r_cnt;
      w_len_next   = r_len;
      w_div_next   = r_div;
      w_step_next  = 1'b0;
      w_wrap_next  = 1'b0;
      if (stop) begin
         w_state_next = S_IDLE;
         w_pos_next   = '0;
         w_cnt_next   = '0;
      end else if (go) begin
         w_pos_next = '0;
         w_cnt_next = '0;
         if (w_len_ok) begin
            w_state_next = S_RUN;
            w_len_next   = len;
            w_div_next   = w_div_eff;
         end else begin
            w_state_next = S_IDLE;
         end
      end else begin
         case (r_state)
            S_RUN, S_PAUSED: begin
               // A paused cycle freezes everything, including a step that would land on it
               if (pause) begin
                  w_state_next = S_PAUSED;
               end else begin
                  w_state_next = S_RUN;
                  if (w_last) begin
                     w_cnt_next  = '0;
                     w_step_next = 1'b1;
                     if (dir) begin
                        w_pos_next  = w_pos_dec;
                        w_wrap_next = ({1'b0, w_pos_dec} == w_len_m1);
                     end else begin
                        w_pos_next  = w_pos_inc;
                        w_wrap_next = (w_pos_inc == '0);
                     end
                  end else begin
                     w_cnt_next = r_cnt + TICK_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign d7   = r_dig[0];
   assign d6   = r_dig[1];
   assign d5   = r_dig[2];
   assign d4   = r_dig[3];
   assign d3   = r_dig[4];
   assign d2   = r_dig[5];
   assign d1   = r_dig[6];
   assign d0   = r_dig[7];
   assign busy = (r_state != S_IDLE);
   assign pos  = r_pos;
   assign step = r_step;
   assign wrap = r_wrap;

endmodule
